// File: rtl/gal_pkg.sv
// Shared definitions for the soft-GAL sum-of-products evaluator.
// Holds the sequencer state encoding and the meaning of the two fuse bits
// that every literal owns inside a product-term row.
package gal_pkg;

  // Sequencer states: waiting for a vector, walking terms, presenting Y.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Offsets of a literal's two fuse bits within its 2-bit slot.
  // A set kill-on-1 bit removes the term when the input bit is 1.
  // A set kill-on-0 bit removes the term when the input bit is 0.
  localparam int KILL_ON_1 = 0;
  localparam int KILL_ON_0 = 1;

  // Total fuse bits for a table of `depth` terms over `width` inputs.
  function automatic int fuse_bits(input int width, input int depth);
    return 2 * width * depth;
  endfunction

endpackage

// File: rtl/gal_term_match.sv
// Evaluates one product term: the term matches unless some literal's
// fuse pattern kills it for the current input vector. An all-clear row
// therefore always matches, and a literal with both fuses set makes the
// term impossible.
module gal_term_match
  import gal_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] row,
  input  logic [WIDTH-1:0]   a,
  output logic               match
);

  // Start from "matches" and let any killing literal clear it.
  always_comb begin
    // NOTE: default assigned first so every path drives match; no latch.
    match = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      if (row[2*j + KILL_ON_1] && a[j]) begin
        match = 1'b0;
      end
      if (row[2*j + KILL_ON_0] && !a[j]) begin
        match = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gal_sop_seq.sv
// Time-multiplexed sum-of-products evaluator.
// A serially loaded fuse table describes DEPTH product terms over WIDTH
// inputs. After a vector is captured, one term is evaluated per clock
// through a single shared matcher, and the OR of all terms is presented
// as a registered result behind a valid/ready handshake.
module gal_sop_seq
  import gal_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             C,
  input  logic             R,
  input  logic             CFG_EN,
  input  logic             CFG_D,
  output logic             CFG_OK,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] A,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             Y
);

  localparam int NB    = fuse_bits(WIDTH, DEPTH);
  localparam int ROW   = 2 * WIDTH;
  localparam int CNT_W = $clog2(NB + 1);
  localparam int FB_W  = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Fuse table, index 0 is the first bit shifted in.
  logic [NB-1:0]    fuse;
  logic [CNT_W-1:0] load_cnt;
  logic             cfg_ok;
  logic [FB_W-1:0]  wr_addr;
  logic             cfg_take;

  // Sequencer state.
  state_t           state;
  logic [WIDTH-1:0] a_cap;
  logic [IDX_W-1:0] idx;
  logic             acc;
  logic             y_q;
  logic             m_valid_q;

  // Shared term matcher.
  logic [ROW-1:0]   row;
  logic             match;
  logic             last_term;

  // Fuse bits are only accepted while idle, so the table never changes
  // underneath an evaluation in progress.
  assign cfg_take = CFG_EN && (state == IDLE);

  // A complete table restarts at index 0; otherwise append at the count.
  assign wr_addr = cfg_ok ? '0 : load_cnt[FB_W-1:0];

  // Shift strobe stalls capture so a vector never races a reload.
  assign S_READY = (state == IDLE) && cfg_ok && !CFG_EN;
  assign CFG_OK  = cfg_ok;
  assign M_VALID = m_valid_q;
  assign Y       = y_q;

  // Row selection for the term currently being evaluated.
  always_comb begin
    row = fuse[ROW*int'(idx) +: ROW];
  end

  assign last_term = (idx == IDX_W'(DEPTH - 1));

  gal_term_match #(
    .WIDTH (WIDTH)
  ) u_match (
    .row   (row),
    .a     (a_cap),
    .match (match)
  );

  // Fuse storage: written one bit per accepted strobe.
  // NOTE: no reset here; the table is always fully reloaded before use,
  // so a reset would only cost a reset net on every storage flop.
  always_ff @(posedge C) begin
    if (cfg_take) begin
      fuse[wr_addr] <= CFG_D;
    end
  end

  // Load counter and completion flag; a strobe after completion begins a
  // fresh load whose first bit counts as index 0.
  always_ff @(posedge C) begin
    // NOTE: all sequential state uses non-blocking assignment so every
    // register samples the pre-edge value of every other register.
    if (R) begin
      load_cnt <= '0;
      cfg_ok   <= 1'b0;
    end else if (cfg_take) begin
      if (cfg_ok) begin
        load_cnt <= CNT_W'(1);
        cfg_ok   <= (NB == 1);
      end else begin
        load_cnt <= load_cnt + 1'b1;
        cfg_ok   <= (load_cnt == CNT_W'(NB - 1));
      end
    end
  end

  // Sequencer: capture, walk every term without early exit, then hold
  // the registered result until the consumer takes it.
  always_ff @(posedge C) begin
    if (R) begin
      state     <= IDLE;
      a_cap     <= '0;
      idx       <= '0;
      acc       <= 1'b0;
      y_q       <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (S_VALID && S_READY) begin
            a_cap <= A;
            acc   <= 1'b0;
            idx   <= '0;
            state <= EVAL;
          end
        end
        EVAL: begin
          acc <= acc | match;
          if (last_term) begin
            y_q       <= acc | match;
            m_valid_q <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        HOLD: begin
          if (M_READY) begin
            m_valid_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          m_valid_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gal_sop_seq.sv
// Bench for gal_sop_seq (WIDTH=2, DEPTH=2). A driver issues captures and
// pushes the expected result into a scoreboard; an independent monitor
// pops and compares whenever M_VALID appears, also checking latency and
// that Y stays put while the result is held.
module tb_gal_sop_seq;

  localparam int W  = 2;
  localparam int D  = 2;
  localparam int NB = 2 * W * D;

  logic         C = 1'b0;
  logic         R;
  logic         CFG_EN;
  logic         CFG_D;
  logic         CFG_OK;
  logic         S_VALID;
  logic         S_READY;
  logic [W-1:0] A;
  logic         M_VALID;
  logic         M_READY;
  logic         Y;

  typedef struct {
    logic y;
    int   cap;
  } exp_t;

  exp_t          sb[$];
  exp_t          cur;
  logic          seen;
  logic          cur_valid;
  logic [NB-1:0] fuse_model;
  int            rdy_mode;
  int            cyc;
  int            errors;
  int            checks;

  gal_sop_seq #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .C       (C),
    .R       (R),
    .CFG_EN  (CFG_EN),
    .CFG_D   (CFG_D),
    .CFG_OK  (CFG_OK),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .A       (A),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .Y       (Y)
  );

  always #5 C = ~C;

  initial cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the output is 1 when some term has no literal that kills
  // it. For each term build the set of inputs that must be 0 and the set
  // that must be 1, then test the vector against both masks.
  function automatic logic ref_sop(input logic [NB-1:0] f, input logic [W-1:0] a);
    logic         any;
    logic [W-1:0] must_be_0;
    logic [W-1:0] must_be_1;
    any = 1'b0;
    for (int t = 0; t < D; t++) begin
      for (int j = 0; j < W; j++) begin
        must_be_0[j] = f[2*W*t + 2*j];
        must_be_1[j] = f[2*W*t + 2*j + 1];
      end
      if (((a & must_be_0) == '0) && ((~a & must_be_1) == '0)) any = 1'b1;
    end
    return any;
  endfunction

  // Monitor: compare each new result, then watch it stay stable.
  always @(negedge C) begin
    if (M_VALID) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          cur_valid = 1'b0;
          checks++;
          errors++;
          $display("FAIL unexpected_m_valid: got M_VALID=1 with no capture outstanding, expected 0 (cycle %0d)", cyc);
        end else begin
          cur       = sb.pop_front();
          cur_valid = 1'b1;
          check("result_y", Y, cur.y);
          check_int("latency", cyc - cur.cap, D);
        end
      end else if (cur_valid) begin
        check("hold_y_stable", Y, cur.y);
      end
    end else begin
      seen = 1'b0;
    end
    if (rdy_mode == 0) M_READY = 1'b1;
    else if (rdy_mode == 1) M_READY = 1'($urandom_range(0, 1));
  end

  // Shift bits [first .. first+n-1] of a table; returns at negedge+1.
  task automatic load(input logic [NB-1:0] bits, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      @(negedge C);
      CFG_EN = 1'b1;
      CFG_D  = bits[i];
    end
    @(negedge C);
    CFG_EN = 1'b0;
    #1;
  endtask

  // Offer a vector, wait (bounded) for capture, then scramble A.
  task automatic send(input logic [W-1:0] a);
    int waited;
    waited = 0;
    @(negedge C);
    S_VALID = 1'b1;
    A       = a;
    #1;
    while (!S_READY && waited < 100) begin
      @(negedge C);
      #1;
      waited++;
    end
    if (!S_READY) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got S_READY=0 for 100 cycles, expected 1");
      S_VALID = 1'b0;
    end else begin
      sb.push_back('{y: ref_sop(fuse_model, a), cap: cyc + 1});
      @(negedge C);
      S_VALID = 1'b0;
      A       = W'($urandom);
    end
  endtask

  // Wait (bounded) until every result is consumed and the DUT is idle.
  task automatic drain();
    int n;
    n = 0;
    @(negedge C);
    #1;
    while ((sb.size() != 0 || M_VALID) && n < 400) begin
      @(negedge C);
      #1;
      n++;
    end
    if (sb.size() != 0 || M_VALID) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NB-1:0] f;
    int            n;
    errors    = 0;
    checks    = 0;
    seen      = 1'b0;
    cur_valid = 1'b0;
    rdy_mode  = 0;
    R         = 1'b1;
    CFG_EN    = 1'b0;
    CFG_D     = 1'b0;
    S_VALID   = 1'b0;
    A         = '0;
    M_READY   = 1'b0;
    fuse_model = '0;

    // Reset state.
    @(negedge C);
    #1;
    check("rst_cfg_ok", CFG_OK, 1'b0);
    check("rst_s_ready", S_READY, 1'b0);
    check("rst_m_valid", M_VALID, 1'b0);
    check("rst_y", Y, 1'b0);
    @(negedge C);
    R = 1'b0;

    // XOR table: CFG_OK only after the eighth bit.
    load(8'h96, 0, 7);
    check("xor_cfg_ok_after7", CFG_OK, 1'b0);
    check("xor_s_ready_after7", S_READY, 1'b0);
    load(8'h96, 7, 1);
    check("xor_cfg_ok_after8", CFG_OK, 1'b1);
    check("xor_s_ready_after8", S_READY, 1'b1);
    fuse_model = 8'h96;
    send(2'b01);
    send(2'b10);
    send(2'b00);
    send(2'b11);
    drain();

    // Back-pressure: result held stable for five cycles.
    rdy_mode = 2;
    M_READY  = 1'b0;
    send(2'b01);
    n = 0;
    #1;
    while (!M_VALID && n < 10) begin
      @(negedge C);
      #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_m_valid", M_VALID, 1'b1);
      check("stall_s_ready", S_READY, 1'b0);
      check("stall_y", Y, 1'b1);
      @(negedge C);
      #1;
    end
    M_READY = 1'b1;
    @(negedge C);
    #1;
    check("stall_release_m_valid", M_VALID, 1'b0);
    check("stall_release_s_ready", S_READY, 1'b1);
    rdy_mode = 0;

    // Dead row 0, always-true row 1; CFG_OK drops on the first new bit.
    load(8'h0F, 0, 1);
    check("reload_cfg_ok_drop", CFG_OK, 1'b0);
    check("reload_s_ready_drop", S_READY, 1'b0);
    load(8'h0F, 1, 7);
    check("reload_cfg_ok", CFG_OK, 1'b1);
    fuse_model = 8'h0F;
    for (int i = 0; i < 4; i++) send(W'(i));
    drain();
    load(8'hFF, 0, NB);
    fuse_model = 8'hFF;
    for (int i = 0; i < 4; i++) send(W'(i));
    drain();

    // Strobe during EVAL is ignored.
    load(8'h96, 0, NB);
    fuse_model = 8'h96;
    send(2'b11);
    CFG_EN = 1'b1;
    CFG_D  = 1'b1;
    #1;
    check("eval_s_ready", S_READY, 1'b0);
    @(negedge C);
    CFG_EN = 1'b0;
    #1;
    check("eval_pulse_cfg_ok", CFG_OK, 1'b1);
    drain();
    send(2'b10);
    drain();

    // Reset during EVAL discards the result and the table.
    send(2'b01);
    R = 1'b1;
    @(negedge C);
    #1;
    sb.delete();
    check("rst_eval_m_valid", M_VALID, 1'b0);
    check("rst_eval_y", Y, 1'b0);
    check("rst_eval_cfg_ok", CFG_OK, 1'b0);
    check("rst_eval_s_ready", S_READY, 1'b0);
    R = 1'b0;
    repeat (6) @(negedge C);
    #1;
    check("rst_eval_no_ready", S_READY, 1'b0);

    // Reset during a partial load; a full reload is then required.
    load(8'h96, 0, 5);
    R = 1'b1;
    @(negedge C);
    #1;
    check("rst_load_cfg_ok", CFG_OK, 1'b0);
    R = 1'b0;
    load(8'h96, 0, 7);
    check("rst_load_cfg_ok_after7", CFG_OK, 1'b0);
    check("rst_load_s_ready_after7", S_READY, 1'b0);
    load(8'h96, 7, 1);
    check("rst_load_cfg_ok_after8", CFG_OK, 1'b1);
    check("rst_load_s_ready_after8", S_READY, 1'b1);
    send(2'b10);
    drain();

    // Random tables, vectors and consumer back-pressure.
    rdy_mode = 1;
    for (int it = 0; it < 30; it++) begin
      f = NB'($urandom);
      load(f, 0, NB);
      fuse_model = f;
      check("rand_cfg_ok", CFG_OK, 1'b1);
      for (int k = 0; k < 5; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge C);
        send(W'($urandom));
      end
      drain();
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
